// File: rtl/core_1553_pkg.sv
// Shared constants and state encoding for the 1553 transmit message sequencer.
// Optional feature macro: TX_IMG_EN adds the inter-message gap (GAP) state.
package core_1553_pkg;

    localparam int unsigned WordW       = 16;
    localparam int unsigned MaxWordsDef = 32;
    localparam int unsigned ImgClksDef  = 8;
    localparam int unsigned CntW        = 6;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSendCsw = 3'd1,
        StWaitHi  = 3'd2,
        StWaitLo  = 3'd3,
        StSendDw  = 3'd4,
`ifdef TX_IMG_EN
        StGap     = 3'd5,
`endif
        StDrain   = 3'd6
    } tx_state_e;

    // Requested word count limited to the per-message maximum.
    function automatic logic [CntW-1:0] clamp_nwords(input logic [CntW-1:0] n,
                                                      input int unsigned   max_w);
        return (32'(n) > max_w) ? CntW'(max_w) : n;
    endfunction

endpackage

// File: rtl/tx_msg_seq_1553.sv
// 1553 transmit message sequencer: sends one command/status word followed by up to
// MAX_WORDS data words, prefetching each data word while the encoder is busy.
// Optional feature macro: TX_IMG_EN inserts an IMG_CLKS-cycle gap before msg_done.
module tx_msg_seq_1553
    import core_1553_pkg::*;
#(
    parameter int unsigned IMG_CLKS  = ImgClksDef,
    parameter int unsigned MAX_WORDS = MaxWordsDef
) (
    input  logic             enc_clk,
    input  logic             rst_n,
    input  logic             msg_start,
    input  logic [WordW-1:0] msg_cmd,
    input  logic [CntW-1:0]  msg_nwords,
    input  logic             msg_abort,
    output logic             msg_busy,
    output logic             msg_done,
    output logic             dw_req,
    output logic [4:0]       dw_idx,
    input  logic             dw_ack,
    input  logic [WordW-1:0] dw_data,
    output logic [WordW-1:0] tx_dword,
    output logic             tx_csw,
    output logic             tx_dw,
    input  logic             tx_busy,
    output logic             err_underrun
);

    tx_state_e        state_q;
    logic [WordW-1:0] cmd_q;
    logic [CntW-1:0]  nwords_q;
    logic [CntW-1:0]  fetch_cnt_q;   // words captured from the data source
    logic [CntW-1:0]  sent_cnt_q;    // words handed to the encoder
    logic             held_q;
    logic [WordW-1:0] held_data_q;
`ifdef TX_IMG_EN
    logic [15:0]      gap_cnt_q;
`endif

    logic             msg_busy_q;
    logic             msg_done_q;
    logic             dw_req_q;
    logic [4:0]       dw_idx_q;
    logic [WordW-1:0] tx_dword_q;
    logic             tx_csw_q;
    logic             tx_dw_q;
    logic             err_underrun_q;

    logic             ack_take;
    logic             dw_consume;
    logic             held_after;
    logic [CntW-1:0]  fetch_after;
    logic             active_st;
    logic             req_cont;
    logic [CntW-1:0]  nwords_clamped;

    // Prefetch bookkeeping as it will stand after this cycle; abort masks the ack.
    always_comb begin
        ack_take       = dw_req_q & dw_ack & ~msg_abort;
        dw_consume     = (state_q == StSendDw) & ~tx_busy & ~msg_abort;
        held_after     = (held_q | ack_take) & ~dw_consume;
        fetch_after    = fetch_cnt_q + {{(CntW-1){1'b0}}, ack_take};
        active_st      = (state_q == StSendCsw) || (state_q == StWaitHi) ||
                         (state_q == StWaitLo)  || (state_q == StSendDw);
        req_cont       = active_st & ~held_after & (fetch_after < nwords_q);
        nwords_clamped = clamp_nwords(msg_nwords, MAX_WORDS);
    end

    // Message FSM with registered strobes, handshake and status outputs.
    always_ff @(posedge enc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cmd_q          <= '0;
            nwords_q       <= '0;
            fetch_cnt_q    <= '0;
            sent_cnt_q     <= '0;
            held_q         <= 1'b0;
            held_data_q    <= '0;
`ifdef TX_IMG_EN
            gap_cnt_q      <= '0;
`endif
            msg_busy_q     <= 1'b0;
            msg_done_q     <= 1'b0;
            dw_req_q       <= 1'b0;
            dw_idx_q       <= '0;
            tx_dword_q     <= '0;
            tx_csw_q       <= 1'b0;
            tx_dw_q        <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            msg_done_q     <= 1'b0;
            err_underrun_q <= 1'b0;
            tx_csw_q       <= 1'b0;
            tx_dw_q        <= 1'b0;
            dw_req_q       <= req_cont;
            dw_idx_q       <= fetch_after[4:0];
            held_q         <= held_after;
            fetch_cnt_q    <= fetch_after;
            if (ack_take) begin
                held_data_q <= dw_data;
            end

            if ((state_q != StIdle) && (state_q != StDrain) && msg_abort) begin
                state_q  <= StDrain;
                dw_req_q <= 1'b0;
                held_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        msg_busy_q <= 1'b0;
                        if (msg_start) begin
                            cmd_q       <= msg_cmd;
                            nwords_q    <= nwords_clamped;
                            fetch_cnt_q <= '0;
                            sent_cnt_q  <= '0;
                            held_q      <= 1'b0;
                            msg_busy_q  <= 1'b1;
                            dw_req_q    <= (nwords_clamped != '0);
                            dw_idx_q    <= '0;
                            state_q     <= StSendCsw;
                        end
                    end
                    StSendCsw: begin
                        if (!tx_busy) begin
                            tx_csw_q   <= 1'b1;
                            tx_dword_q <= cmd_q;
                            state_q    <= StWaitHi;
                        end
                    end
                    StWaitHi: begin
                        if (tx_busy) begin
                            state_q <= StWaitLo;
                        end
                    end
                    StWaitLo: begin
                        if (!tx_busy) begin
                            if (sent_cnt_q < nwords_q) begin
                                if (held_q) begin
                                    state_q <= StSendDw;
                                end else begin
                                    // Data source missed the slot: abandon the message.
                                    err_underrun_q <= 1'b1;
                                    dw_req_q       <= 1'b0;
                                    state_q        <= StIdle;
                                end
                            end else begin
                                dw_req_q <= 1'b0;
`ifdef TX_IMG_EN
                                gap_cnt_q <= '0;
                                state_q   <= StGap;
`else
                                msg_done_q <= 1'b1;
                                state_q    <= StIdle;
`endif
                            end
                        end
                    end
                    StSendDw: begin
                        if (!tx_busy) begin
                            tx_dw_q    <= 1'b1;
                            tx_dword_q <= held_data_q;
                            sent_cnt_q <= sent_cnt_q + 1'b1;
                            state_q    <= StWaitHi;
                        end
                    end
`ifdef TX_IMG_EN
                    StGap: begin
                        if (32'(gap_cnt_q) + 32'd1 >= IMG_CLKS) begin
                            msg_done_q <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 16'd1;
                        end
                    end
`endif
                    StDrain: begin
                        if (!tx_busy) begin
                            msg_busy_q <= 1'b0;
                            state_q    <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign msg_busy     = msg_busy_q;
    assign msg_done     = msg_done_q;
    assign dw_req       = dw_req_q;
    assign dw_idx       = dw_idx_q;
    assign tx_dword     = tx_dword_q;
    assign tx_csw       = tx_csw_q;
    assign tx_dw        = tx_dw_q;
    assign err_underrun = err_underrun_q;

endmodule

// File: tb/tb_tx_msg_seq_1553.sv
// Self-checking bench for tx_msg_seq_1553: table of whole-message scenarios plus
// hand-written reset sequences. Works with or without TX_IMG_EN.
module tb_tx_msg_seq_1553;

`ifdef TX_IMG_EN
    localparam int ExpGap = 8;
`else
    localparam int ExpGap = 0;
`endif

    logic        enc_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msg_start = 1'b0;
    logic [15:0] msg_cmd = '0;
    logic [5:0]  msg_nwords = '0;
    logic        msg_abort = 1'b0;
    logic        msg_busy;
    logic        msg_done;
    logic        dw_req;
    logic [4:0]  dw_idx;
    logic        dw_ack = 1'b0;
    logic [15:0] dw_data = '0;
    logic [15:0] tx_dword;
    logic        tx_csw;
    logic        tx_dw;
    logic        tx_busy;
    logic        err_underrun;

    tx_msg_seq_1553 #(
        .IMG_CLKS  (8),
        .MAX_WORDS (32)
    ) dut (
        .enc_clk      (enc_clk),
        .rst_n        (rst_n),
        .msg_start    (msg_start),
        .msg_cmd      (msg_cmd),
        .msg_nwords   (msg_nwords),
        .msg_abort    (msg_abort),
        .msg_busy     (msg_busy),
        .msg_done     (msg_done),
        .dw_req       (dw_req),
        .dw_idx       (dw_idx),
        .dw_ack       (dw_ack),
        .dw_data      (dw_data),
        .tx_dword     (tx_dword),
        .tx_csw       (tx_csw),
        .tx_dw        (tx_dw),
        .tx_busy      (tx_busy),
        .err_underrun (err_underrun)
    );

    always #5 enc_clk = ~enc_clk;

    // Encoder model: busy for busy_len cycles after each accepted strobe.
    int busy_len = 20;
    int busy_cnt = 0;
    always @(posedge enc_clk) begin
        if (tx_csw || tx_dw) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Data source model: acks ack_delay cycles after dw_req, at most ack_limit times.
    logic [15:0] word_tab [32];
    int ack_delay = 2;
    int ack_limit = 32;
    int acks_given = 0;
    int req_age = 0;
    initial begin
        forever begin
            @(negedge enc_clk);
            dw_ack = 1'b0;
            if (!msg_busy) begin
                acks_given = 0;
                req_age    = 0;
            end else if (dw_req) begin
                if (req_age >= ack_delay && acks_given < ack_limit) begin
                    dw_ack     = 1'b1;
                    dw_data    = word_tab[dw_idx];
                    acks_given = acks_given + 1;
                    req_age    = 0;
                end else begin
                    req_age = req_age + 1;
                end
            end else begin
                req_age = 0;
            end
        end
    end

    typedef struct {
        logic [15:0] cmd;
        logic [5:0]  nwords;
        int          ack_delay;
        int          ack_limit;
        int          busy_len;
        int          abort_at;    // abort when this many data strobes seen and dw_req high
        bit          abort_idle;  // msg_abort together with msg_start
        bit          spur;        // extra msg_start pulses while the message runs
        int          exp_dw;
        int          exp_req;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs [7];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    logic [15:0] dw_q [$];
    int          idx_q [$];

    task automatic run_case(input int k, input vec_t v);
        int cyc, n_csw, n_done, n_err, viol, done_cyc, err_cyc, last_fall, busy_fall;
        int abort_cyc, bad;
        logic [15:0] csw_word;
        logic prev_req, prev_tbusy, aborted, abort_drop;
        string p;
        p = $sformatf("v%0d_", k);
        n_csw = 0; n_done = 0; n_err = 0; viol = 0; done_cyc = -1; err_cyc = -1;
        last_fall = -100; busy_fall = -1; abort_cyc = -1; csw_word = '0;
        aborted = 1'b0; abort_drop = 1'b0;
        dw_q.delete();
        idx_q.delete();
        ack_delay = v.ack_delay;
        ack_limit = v.ack_limit;
        busy_len  = v.busy_len;

        @(negedge enc_clk);
        msg_cmd    = v.cmd;
        msg_nwords = v.nwords;
        msg_start  = 1'b1;
        msg_abort  = v.abort_idle;
        @(negedge enc_clk);
        msg_start  = 1'b0;
        msg_abort  = 1'b0;
        msg_cmd    = 16'hDEAD;   // must not leak into the latched command
        msg_nwords = 6'd7;
        check({p, "busy_t1"}, 32'(msg_busy), 32'd1);
        prev_req   = 1'b0;
        prev_tbusy = tx_busy;
        cyc = 1;
        while (cyc < 3000) begin
            if (tx_csw) begin
                n_csw++;
                csw_word = tx_dword;
            end
            if (tx_dw) dw_q.push_back(tx_dword);
            if (msg_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (err_underrun) begin
                n_err++;
                err_cyc = cyc;
            end
            if (dw_req && !prev_req) idx_q.push_back(int'(dw_idx));
            if ((tx_csw || tx_dw) && tx_busy) viol++;
            if (!tx_busy && prev_tbusy) last_fall = cyc;
            if (!msg_busy && busy_fall < 0) busy_fall = cyc;
            if (aborted && cyc == abort_cyc + 1) abort_drop = !dw_req && !tx_csw && !tx_dw;
            prev_req   = dw_req;
            prev_tbusy = tx_busy;
            msg_abort  = 1'b0;
            msg_start  = 1'b0;
            if (v.abort_at > 0 && !aborted && dw_q.size() == v.abort_at && dw_req) begin
                msg_abort = 1'b1;
                aborted   = 1'b1;
                abort_cyc = cyc;
            end
            if (v.spur && msg_busy && n_done == 0 && n_err == 0 &&
                (cyc == 10 || cyc == last_fall + 3)) msg_start = 1'b1;
            if (busy_fall >= 0 && cyc >= busy_fall + 6) break;
            @(negedge enc_clk);
            cyc++;
        end
        msg_start = 1'b0;
        msg_abort = 1'b0;

        check({p, "finished"}, 32'(busy_fall >= 0), 32'd1);
        check({p, "n_csw"}, 32'(n_csw), 32'd1);
        check({p, "csw_word"}, 32'(csw_word), 32'(v.cmd));
        check({p, "n_dw"}, 32'(dw_q.size()), 32'(v.exp_dw));
        bad = 0;
        foreach (dw_q[i]) if (i < 32 && dw_q[i] !== word_tab[i]) bad++;
        check({p, "dw_words_bad"}, 32'(bad), 32'd0);
        check({p, "n_req"}, 32'(idx_q.size()), 32'(v.exp_req));
        bad = 0;
        foreach (idx_q[i]) if (idx_q[i] != i) bad++;
        check({p, "dw_idx_bad"}, 32'(bad), 32'd0);
        check({p, "n_done"}, 32'(n_done), 32'(v.exp_done));
        check({p, "n_err"}, 32'(n_err), 32'(v.exp_err));
        check({p, "strobe_in_busy"}, 32'(viol), 32'd0);
        if (v.exp_done) begin
            check({p, "done_cyc"}, 32'(done_cyc), 32'(last_fall + 1 + ExpGap));
            check({p, "busy_fall"}, 32'(busy_fall), 32'(done_cyc + 1));
        end
        if (v.exp_err) begin
            check({p, "err_cyc"}, 32'(err_cyc), 32'(last_fall + 1));
            check({p, "busy_fall"}, 32'(busy_fall), 32'(err_cyc + 1));
        end
        if (v.abort_at > 0) begin
            check({p, "abort_hit"}, 32'(aborted), 32'd1);
            check({p, "abort_drop"}, 32'(abort_drop), 32'd1);
            check({p, "busy_fall"}, 32'(busy_fall), 32'(last_fall + 1));
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {5'd0, msg_busy, msg_done, dw_req, dw_idx, tx_dword, tx_csw, tx_dw, err_underrun};
    endfunction

    initial begin
        int stray;
        for (int i = 0; i < 32; i++) word_tab[i] = 16'h5A00 + 16'(i);
        word_tab[0] = 16'h00A1;
        word_tab[1] = 16'h00B2;
        word_tab[2] = 16'h00C3;

        //           cmd       nw     dly lim busy abt ai sp  dw  req dn er
        vecs[0] = '{16'h1234, 6'd0,  2, 32, 39, 0, 0, 0, 0,  0,  1, 0};
        vecs[1] = '{16'hC0DE, 6'd3,  2, 32, 20, 0, 0, 1, 3,  3,  1, 0};
        vecs[2] = '{16'h4242, 6'd2,  2, 1,  20, 0, 0, 0, 1,  2,  0, 1};
        vecs[3] = '{16'h8001, 6'd32, 0, 32, 6,  0, 0, 0, 32, 32, 1, 0};
        vecs[4] = '{16'h0F0F, 6'd5,  0, 32, 39, 2, 0, 0, 2,  3,  0, 0};
        vecs[5] = '{16'h7777, 6'd40, 0, 32, 6,  0, 0, 0, 32, 32, 1, 0};
        vecs[6] = '{16'hA5A5, 6'd1,  2, 32, 10, 0, 1, 0, 1,  1,  1, 0};

        repeat (3) @(negedge enc_clk);
        check("reset_outputs", out_vec(), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge enc_clk);
        check("idle_after_reset", out_vec(), 32'd0);

        for (int k = 0; k < 7; k++) run_case(k, vecs[k]);

        // Reset in the middle of a message: everything clears, nothing follows.
        ack_delay = 2;
        ack_limit = 32;
        busy_len  = 20;
        @(negedge enc_clk);
        msg_cmd    = 16'hBEEF;
        msg_nwords = 6'd3;
        msg_start  = 1'b1;
        @(negedge enc_clk);
        msg_start = 1'b0;
        repeat (30) @(negedge enc_clk);
        check("rst_mid_busy", 32'(msg_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge enc_clk);
        check("rst_mid_outputs", out_vec(), 32'd0);
        rst_n = 1'b1;
        stray = 0;
        repeat (80) begin
            @(negedge enc_clk);
            if (msg_busy || msg_done || err_underrun || tx_csw || tx_dw || dw_req) stray++;
        end
        check("rst_no_pulses", 32'(stray), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_msg_seq_1553.md
TX_MSG_SEQ_1553 -- requirements
Module: tx_msg_seq_1553

Interface
REQ-001 SHALL have parameter IMG_CLKS, default 8, inter-message gap length in enc_clk cycles (used only with TX_IMG_EN).
REQ-002 SHALL have parameter MAX_WORDS, default 32, maximum data words per message.
REQ-003 SHALL have ports: enc_clk  in  1  2 MHz encoder clock; the block uses this single clock.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port msg_start  in  1  one-cycle request to send a message; honoured only in IDLE.
REQ-006 SHALL have port msg_cmd  in  16  command/status word, bit 0 = MSB, latched on accepted msg_start.
REQ-007 SHALL have port msg_nwords  in  6  data-word count 0..32, latched on accepted msg_start; values above 32 are clamped to 32.
REQ-008 SHALL have port msg_abort  in  1  one-cycle abort of the current message.
REQ-009 SHALL have ports msg_busy  out  1  (message in progress) and msg_done  out  1  (one-cycle completion pulse).
REQ-010 SHALL have ports dw_req  out  1  (data word wanted), dw_idx  out  5  (index of wanted word), dw_ack  in  1, dw_data  in  16.
REQ-011 SHALL have ports tx_dword  out  16, tx_csw  out  1, tx_dw  out  1 (encoder strobes), tx_busy  in  1 (encoder busy).
REQ-012 SHALL have port err_underrun  out  1  one-cycle pulse on data-word underrun.

Function
REQ-013 SHALL implement states IDLE, SEND_CSW, WAIT_HI, WAIT_LO, SEND_DW, GAP (TX_IMG_EN only), and DRAIN.
REQ-014 IDLE + msg_start at cycle T: SHALL latch msg_cmd and msg_nwords, and assert msg_busy from T+1.
REQ-015 SEND_CSW: SHALL drive tx_dword = latched cmd with tx_csw = 1 for exactly one cycle, in the first cycle tx_busy is sampled 0, then enter WAIT_HI.
REQ-016 WAIT_HI: SHALL wait for tx_busy = 1, then enter WAIT_LO; tx_csw and tx_dw are never asserted while tx_busy = 1.
REQ-017 Prefetch: while data words remain and no word is held, SHALL assert dw_req with dw_idx = index of the next word (0-based).
REQ-018 Prefetch: the dw_ack cycle captures dw_data, dw_req SHALL drop the following cycle, and dw_ack with dw_req low SHALL be ignored.
REQ-019 WAIT_LO on tx_busy = 0: if words remain and one is held, SHALL enter SEND_DW and pulse tx_dw for one cycle with tx_dword = held word, then enter WAIT_HI.
REQ-020 WAIT_LO on tx_busy = 0 with words remaining and no held word: SHALL pulse err_underrun, skip msg_done, and return to IDLE.
REQ-021 WAIT_LO on tx_busy = 0 with no words remaining: SHALL enter GAP (TX_IMG_EN) or pulse msg_done and return to IDLE.
REQ-022 msg_nwords = 0 SHALL send the command word only, with dw_req never asserted.
REQ-023 Word counter SHALL be 6 bits, so that count 32 does not wrap, and dw_idx SHALL equal the counter's low 5 bits.
REQ-024 msg_abort in any non-IDLE state: SHALL drop dw_req and strobes next cycle, enter DRAIN, wait tx_busy = 0, then go IDLE without msg_done or err_underrun.
REQ-025 msg_abort SHALL take priority over a simultaneous dw_ack or state transition, and msg_abort in IDLE SHALL be ignored.
REQ-026 msg_start outside IDLE SHALL be ignored.
REQ-027 msg_busy SHALL deassert the cycle after msg_done, err_underrun, or DRAIN exit.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On rst_n low: state = IDLE, all outputs 0 (tx_dword = 0, dw_idx = 0), held-word flag cleared, counters 0.
REQ-030 Reset asserted mid-message SHALL abandon the message silently, with no pulses after release.

Configuration
REQ-031 With TX_IMG_EN defined: after the last word, GAP SHALL count IMG_CLKS cycles with msg_busy high, then pulse msg_done.
REQ-032 Without TX_IMG_EN: GAP state, its counter, and IMG_CLKS usage SHALL be absent, and msg_done SHALL pulse the cycle after the final tx_busy fall is sampled.

Structure
REQ-033 Package core_1553_pkg SHALL hold the state enum, MAX_WORDS, word width (16), and IMG_CLKS default.
REQ-034 No sub-module; a single flat module is natural.

Verification
REQ-035 cmd = 16'h1234, nwords = 0, encoder model busy 39 cycles -> one tx_csw pulse, no dw_req, msg_done after busy falls.
REQ-036 nwords = 3, dw_ack 2 cycles after each dw_req, data A1/B2/C3 -> tx_dw pulses carry 16'h00A1, 16'h00B2, 16'h00C3 in order, dw_idx 0, 1, 2, one msg_done.
REQ-037 nwords = 2, second dw_ack withheld past busy fall -> err_underrun pulse, no msg_done, IDLE, msg_busy low the next cycle.
REQ-038 nwords = 32, immediate acks -> 33 strobes, dw_idx runs 0..31 without wrap error, msg_done once.
REQ-039 msg_abort during word 1 of 5 -> dw_req low next cycle, no further strobes, msg_busy low the cycle after tx_busy falls, no msg_done.
REQ-040 TX_IMG_EN with IMG_CLKS = 8 -> msg_done 8 cycles later than in the non-macro build; msg_start during GAP ignored.
